// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: streams bytes into a small FIFO and presents whole
// 6502 instructions to decode. Optional stall counter under IFETCH_PERF_CNT_EN.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_addr,
  output logic        mem_rd_en,
  input  logic        mem_grant,
  input  logic [7:0]  mem_data,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [7:0]  dec_opcode,
  output logic [15:0] dec_operand,
  output logic [1:0]  dec_len,
  output logic [15:0] dec_pc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    fifo [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          inflight;
  logic [15:0]   fetch_pc, head_pc;
  logic [7:0]    byte1, byte2;
  logic          capture, handshake;

  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [2:0] b;
    b = op[4:2];
    op_len = 2'd1;
    case (op[1:0])
      2'b01: op_len = (b == 3'd3 || b == 3'd6 || b == 3'd7) ? 2'd3 : 2'd2;
      2'b10: begin
        if (b == 3'd3 || b == 3'd7) op_len = 2'd3;
        else if (b == 3'd0 || b == 3'd1 || b == 3'd5) op_len = 2'd2;
      end
      2'b00: begin
        // bbb=000 mixes JSR (3), BRK/RTI/RTS (1) and immediates (2)
        if (b == 3'd0) begin
          if (op == 8'h20) op_len = 2'd3;
          else if (op == 8'h00 || op == 8'h40 || op == 8'h60) op_len = 2'd1;
          else op_len = 2'd2;
        end else if (b == 3'd3 || b == 3'd7) op_len = 2'd3;
        else if (b == 3'd1 || b == 3'd4 || b == 3'd5) op_len = 2'd2;
      end
      default: op_len = 2'd1;
    endcase
  endfunction

  assign dec_opcode  = fifo[rd_ptr];
  assign byte1       = fifo[rd_ptr + AW'(1)];
  assign byte2       = fifo[rd_ptr + AW'(2)];
  assign dec_len     = op_len(dec_opcode);
  assign dec_operand = {(dec_len == 2'd3) ? byte2 : 8'h00,
                        (dec_len >= 2'd2) ? byte1 : 8'h00};
  assign dec_pc      = head_pc;
  assign dec_valid   = (count >= CW'(dec_len)) & ~redirect;

  assign mem_addr  = fetch_pc;
  assign mem_rd_en = rst_n & mem_grant & ~redirect & ((count + CW'(inflight)) < CW'(DEPTH));

  // A returning byte is dropped if a redirect lands on its return cycle
  assign capture   = inflight & ~redirect;
  assign handshake = dec_valid & dec_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
    end else if (redirect) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      fetch_pc <= redirect_pc;
      head_pc  <= redirect_pc;
    end else begin
      inflight <= mem_rd_en;
      if (mem_rd_en) fetch_pc <= fetch_pc + 16'd1;
      if (capture) wr_ptr <= wr_ptr + AW'(1);
      if (handshake) begin
        rd_ptr  <= rd_ptr + AW'(dec_len);
        head_pc <= head_pc + 16'(dec_len);
      end
      count <= count + CW'(capture) - (handshake ? CW'(dec_len) : CW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (capture) fifo[wr_ptr] <= mem_data;
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (dec_ready && !dec_valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: the expected instruction stream is walked
// straight out of a memory image; a negedge monitor checks fetches and handshakes.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_grant = 1'b1;
  logic [7:0]  mem_data = 8'h00;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  logic [7:0]  dec_opcode;
  logic [15:0] dec_operand;
  logic [1:0]  dec_len;
  logic [15:0] dec_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif

  ifetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_grant(mem_grant), .mem_data(mem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
    .dec_operand(dec_operand), .dec_len(dec_len), .dec_pc(dec_pc)
`ifdef IFETCH_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem_model [0:65535];
  always @(posedge clk) if (mem_rd_en) mem_data <= mem_model[mem_addr];

  typedef struct {
    logic [7:0]  op;
    logic [15:0] operand;
    logic [1:0]  len;
    logic [15:0] pc;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] next_pc;
  logic [15:0] exp_fetch;
  int          checks = 0;
  int          failures = 0;
  int          n_pop = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Instruction length straight from the opcode-group rules
  function automatic logic [1:0] ref_len(input logic [7:0] op);
    int b;
    b = int'(op[4:2]);
    case (op[1:0])
      2'b11: return 2'd1;
      2'b01: return (b == 3 || b == 6 || b == 7) ? 2'd3 : 2'd2;
      2'b10: return (b == 3 || b == 7) ? 2'd3 : ((b == 0 || b == 1 || b == 5) ? 2'd2 : 2'd1);
      default: begin
        if (b == 0) return (op == 8'h20) ? 2'd3 : ((op == 8'h00 || op == 8'h40 || op == 8'h60) ? 2'd1 : 2'd2);
        return (b == 3 || b == 7) ? 2'd3 : ((b == 2 || b == 6) ? 2'd1 : 2'd2);
      end
    endcase
  endfunction

  task automatic push_program(input logic [15:0] pc, input int n);
    exp_t e;
    logic [15:0] p;
    p = pc;
    for (int i = 0; i < n; i++) begin
      e.op      = mem_model[p];
      e.len     = ref_len(e.op);
      e.pc      = p;
      e.operand = {(e.len == 2'd3) ? mem_model[p + 16'd2] : 8'h00,
                   (e.len >= 2'd2) ? mem_model[p + 16'd1] : 8'h00};
      sbq.push_back(e);
      p = p + 16'(e.len);
    end
    next_pc = p;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rst_n && sbq.size() < 16) push_program(next_pc, 16);
  endtask

  task automatic reset_begin();
    rst_n = 1'b0;
    redirect = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
`ifdef IFETCH_PERF_CNT_EN
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    step();
  endtask

  task automatic reset_end();
    push_program(16'h0000, 32);
    rst_n = 1'b1;
  endtask

  // Monitor: fetch address continuity, redirect quietness, instruction scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_fetch = 16'h0000;
    end else if (redirect) begin
      chk("redirect_quiet", {62'd0, dec_valid, mem_rd_en}, 64'd0);
      exp_fetch = redirect_pc;
    end else begin
      if (mem_rd_en) begin
        chk("fetch_addr", 64'(mem_addr), 64'(exp_fetch));
        exp_fetch = exp_fetch + 16'd1;
      end
      if (dec_valid && dec_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow actual=handshake pc=%h expected=no_instruction", dec_pc);
        end else begin
          e = sbq.pop_front();
          n_pop++;
          chk("instr", {22'd0, dec_opcode, dec_operand, dec_len, dec_pc},
                       {22'd0, e.op, e.operand, e.len, e.pc});
        end
      end
    end
  end

  int  nfetch;
  int  k;
  bit  got;

  initial begin
    for (int a = 0; a < 65536; a++) mem_model[a] = 8'hEA;

    // 1: NOPs from reset, first valid in cycle 2
    reset_begin();
    mem_grant = 1'b1;
    dec_ready = 1'b1;
    reset_end();
    @(negedge clk);
    chk("c0_valid", 64'(dec_valid), 64'd0);
    chk("c0_fetch", {47'd0, mem_rd_en, mem_addr}, {47'd0, 1'b1, 16'h0000});
    step();
    @(negedge clk);
    chk("c1_valid", 64'(dec_valid), 64'd0);
    step();
    @(negedge clk);
    chk("c2_instr", {39'd0, dec_valid, dec_opcode, dec_len, dec_pc},
                    {39'd0, 1'b1, 8'hEA, 2'd1, 16'h0000});
`ifdef IFETCH_PERF_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'd2);
`endif
    step();

    // 2: JMP $1234 is a 3-byte instruction, valid in cycle 4
    reset_begin();
    mem_model[0] = 8'h4C; mem_model[1] = 8'h34; mem_model[2] = 8'h12;
    reset_end();
    repeat (3) begin @(negedge clk); step(); end
    @(negedge clk);
    chk("jmp_c3_valid", 64'(dec_valid), 64'd0);
    step();
    @(negedge clk);
    chk("jmp_instr", {23'd0, dec_valid, dec_len, dec_operand, dec_pc},
                     {23'd0, 1'b1, 2'd3, 16'h1234, 16'h0000});
    step();
    @(negedge clk);
    chk("jmp_next_pc", {47'd0, dec_valid, dec_pc}, {47'd0, 1'b1, 16'h0003});
    step();

    // 3: decode stalled -> exactly DEPTH bytes fetched
    reset_begin();
    mem_model[0] = 8'hEA; mem_model[1] = 8'hEA; mem_model[2] = 8'hEA;
    dec_ready = 1'b0;
    reset_end();
    nfetch = 0;
    repeat (12) begin
      @(negedge clk);
      if (mem_rd_en) nfetch++;
      step();
    end
    chk("full_fetch_cnt", 64'(nfetch), 64'd4);
    @(negedge clk);
    chk("full_state", {62'd0, mem_rd_en, dec_valid}, {62'd0, 1'b0, 1'b1});
    step();
    dec_ready = 1'b1;

    // 4: redirect to FFFE with a byte in flight
    repeat (6) step();
    @(negedge clk);
    chk("inflight_before_redirect", 64'(mem_rd_en), 64'd1);
    step();
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    mem_model[16'hFFFE] = 8'hA9; mem_model[16'hFFFF] = 8'h55;
    sbq.delete();
    push_program(16'hFFFE, 32);
    @(negedge clk);
    step();
    redirect = 1'b0;
    got = 1'b0;
    k = 0;
    while (!got && k < 10) begin
      @(negedge clk);
      k++;
      if (dec_valid) got = 1'b1;
      else step();
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL redirect_timeout actual=no_valid expected=valid_within_10");
    end else begin
      chk("redirect_latency", 64'(k), 64'd4);
      chk("redirect_instr", {30'd0, dec_opcode, dec_operand, dec_len, dec_pc},
                            {30'd0, 8'hA9, 16'h0055, 2'd2, 16'hFFFE});
    end
    step();

    // 5: grant toggling every cycle
    for (int i = 0; i < 40; i++) begin
      mem_grant = (i % 2) == 0;
      step();
    end
    mem_grant = 1'b1;

    // 6: randomized grant/ready/redirect against a random memory image
    redirect = 1'b1;
    redirect_pc = 16'(($urandom));
    for (int a = 0; a < 65536; a++) mem_model[a] = 8'($urandom);
    sbq.delete();
    push_program(redirect_pc, 16);
    step();
    for (int c = 0; c < 3000; c++) begin
      mem_grant = ($urandom_range(0, 9) < 7);
      dec_ready = ($urandom_range(0, 9) < 6);
      redirect  = ($urandom_range(0, 99) < 3);
      if (redirect) begin
        redirect_pc = 16'($urandom);
        sbq.delete();
        push_program(redirect_pc, 16);
      end
      step();
    end
    redirect = 1'b0;
    mem_grant = 1'b1;
    dec_ready = 1'b1;
    repeat (10) step();
    chk("handshakes_seen", 64'(n_pop > 300), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction prefetch queue for the 6502 core, directly upstream of `decode_stage`. It streams opcode and operand bytes from memory into a byte FIFO whenever the execute stage is not using the bus. It computes each opcode's instruction length and presents a complete instruction (opcode, operands, PC) to decode with a valid/ready handshake. A redirect from execute (jump, branch, return) flushes the queue and restarts fetching at the new PC.

## Interface
- `DEPTH`, 4: byte FIFO entries; power of two, minimum 4.
- `RESET_PC`, 16'h0000: fetch address after reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_addr` out 16: fetch address; equals `fetch_pc`.
- `mem_rd_en` out 1: read request this cycle.
- `mem_grant` in 1: bus is free for fetch this cycle (execute not accessing memory).
- `mem_data` in 8: read data, valid the cycle after a granted request.
- `redirect` in 1: flush the queue and restart fetching.
- `redirect_pc` in 16: new fetch address; sampled when `redirect`=1.
- `dec_valid` out 1: a complete instruction is at the head.
- `dec_ready` in 1: decode accepts the head instruction.
- `dec_opcode` out 8: head byte.
- `dec_operand` out 16: `{byte2,byte1}`; bytes beyond the instruction length read as 0.
- `dec_len` out 2: instruction length, 1 to 3.
- `dec_pc` out 16: address of the opcode.
- `stall_cnt` out 16: present only with `IFETCH_PERF_CNT_EN`.

## Operation
- State:
  - `fetch_pc`
  - `head_pc`
  - FIFO read/write pointers and `count` (0..DEPTH)
  - `inflight` flag
- Read issue: `mem_rd_en = mem_grant & ~redirect & (count + inflight < DEPTH)`.
  - On issue: `fetch_pc` increments by 1 (wraps FFFF to 0000) and `inflight` is set for the next cycle.
- Data capture: when `inflight`=1, `mem_data` is written at the write pointer and `count` increments. A capture and a same-cycle issue are both permitted.
- Length from the head opcode `aaabbbcc`:
  - cc=01: bbb in {011,110,111} gives 3; otherwise 2.
  - cc=10: bbb in {011,111} gives 3; bbb in {000,001,101} gives 2; otherwise 1.
  - cc=00:
    - 20 gives 3; 00, 40, 60 give 1; other bbb=000 opcodes give 2.
    - bbb in {011,111} gives 3; bbb in {001,100,101} gives 2; bbb in {010,110} gives 1.
  - cc=11 (illegal): 1.
- Decode outputs:
  - `dec_valid = (count >= dec_len) & ~redirect`.
  - The outputs are combinational from the FIFO head entries.
- Handshake: on `dec_valid & dec_ready`, the read pointer and `count` drop by `dec_len`, and `head_pc` advances by `dec_len` modulo 2^16.
  - If a capture happens in the same cycle, `count` changes by +1-`dec_len`.
- Redirect:
  - `count`=0, pointers=0, `fetch_pc`=`head_pc`=`redirect_pc`.
  - An outstanding in-flight byte is discarded on its return cycle.
  - Redirect has priority over capture and issue in the same cycle.
  - A handshake in the redirect cycle cannot occur, because `dec_valid` is forced 0.
- Grant low: no issue. Held bytes remain available to decode.
- Full: no issue while `count + inflight = DEPTH`.
- Empty, or a partial instruction at the head: `dec_valid`=0 and the outputs are don't-care.

## Timing
- Reset values: `fetch_pc`=`head_pc`=`RESET_PC`, `count`=0, `inflight`=0, `dec_valid`=0, `mem_rd_en`=0 while `rst_n`=0, `stall_cnt`=0.
  - Reset asserted mid-operation drops all queued and in-flight bytes immediately.
- Memory latency is 1 cycle: a request in cycle N is captured at the end of cycle N+1, and its byte is usable at the head in cycle N+2.
- Minimum latency with continuous grant:
  - From reset release or redirect to `dec_valid` is 2 cycles for a 1-byte instruction and 4 cycles for a 3-byte instruction.
  - The redirect cycle itself issues nothing; fetching starts the next cycle.
- Sustained throughput with continuous grant is 1 byte per cycle.

## Configuration
- `IFETCH_PERF_CNT_EN` defined:
  - Adds `stall_cnt`, which increments every cycle with `dec_ready`=1 and `dec_valid`=0.
  - The counter saturates at FFFF and clears on reset only.
- Not defined: no `stall_cnt` port or counter logic; all other behaviour is identical.

## Test plan
- Reset release, `RESET_PC`=0000, memory holds EA at 0000, grant always 1, `dec_ready`=1 -> `mem_addr` sequence 0000,0001,..., and `dec_valid` in cycle 2 with `dec_opcode`=EA, `dec_len`=1, `dec_pc`=0000.
- Memory holds 4C 34 12 -> one handshake with `dec_len`=3, `dec_operand`=1234, `dec_pc`=0000; the next `dec_pc`=0003.
- `dec_ready`=0 with DEPTH=4 -> exactly 4 bytes fetched, then `mem_rd_en`=0 and `count`=4.
- Grant toggling 1/0 every cycle -> fetch addresses remain contiguous with no skipped or duplicated byte.
- `redirect` with `redirect_pc`=FFFE while a byte is in flight -> the stale byte is dropped, fetch order is FFFE, FFFF, 0000, and the first `dec_pc`=FFFE.
- With `IFETCH_PERF_CNT_EN`: `dec_ready`=1 for 3 cycles after reset release -> `stall_cnt`=2.
